// File: rtl/fir_decim_mc_pkg.sv
// Shared types and helpers for the multi-channel decimating FIR.
// sat_trunc handles accumulators up to SAT_ACC_W bits and samples up to SAT_OUT_W bits.
package fir_decim_mc_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_OUT
  } state_e;

  localparam int unsigned SAT_ACC_W = 160;
  localparam int unsigned SAT_OUT_W = 64;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned taps);
    return 2 * dw + $clog2(taps);
  endfunction

  // Arithmetic shift, then optional clamp to the signed dw-bit range; caller keeps the low dw bits.
  function automatic logic [SAT_OUT_W-1:0] sat_trunc(input logic signed [SAT_ACC_W-1:0] acc,
                                                     input int unsigned frac,
                                                     input bit sat,
                                                     input int unsigned dw);
    logic signed [SAT_ACC_W-1:0] r;
    logic signed [SAT_ACC_W-1:0] hi;
    logic signed [SAT_ACC_W-1:0] lo;
    r  = acc >>> frac;
    hi = (SAT_ACC_W'(1) <<< (dw - 1)) - SAT_ACC_W'(1);
    lo = -hi - SAT_ACC_W'(1);
    if (sat && (r > hi)) begin
      r = hi;
    end else if (sat && (r < lo)) begin
      r = lo;
    end
    return r[SAT_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fir_decim_mc_if.sv
// Input-FIFO read side and output-FIFO write side of the decimating FIR.
interface fir_decim_mc_if #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned CH_W = $clog2(CHANNELS) + 1;

  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                           in_empty;
  logic                           in_rd_en;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [CH_W-1:0]                out_chan;
  logic                           out_full;
  logic                           out_wr_en;

  modport slave (
    input  in_data, in_empty, out_full,
    output in_rd_en, out_data, out_chan, out_wr_en
  );

  modport master (
    output in_data, in_empty, out_full,
    input  in_rd_en, out_data, out_chan, out_wr_en
  );
endinterface

// File: rtl/fir_decim_mc_mac_lane.sv
// Combinational MAC lane: N signed products summed into a SW-bit partial sum.
module fir_mac_lane #(
  parameter int unsigned N  = 1,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = 2 * DW
) (
  input  logic signed [DW-1:0] samp_i [N],
  input  logic signed [DW-1:0] coef_i [N],
  output logic signed [SW-1:0] sum_o
);

  logic signed [2*DW-1:0] prod [N];

  always_comb begin
    prod  = '{default: '0};
    sum_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      prod[i] = samp_i[i] * coef_i[i];
      sum_o   = sum_o + SW'(prod[i]);
    end
  end

endmodule

// File: rtl/fir_decim_mc.sv
// Time-multiplexed decimating FIR: per-channel histories, shared MAC lane, one output burst
// of CHANNELS results every DECIMATION_FACTOR input reads.
module fir_decim_mc
  import fir_decim_mc_pkg::*;
#(
  parameter int unsigned TAP_COUNT         = 32,
  parameter int unsigned DECIMATION_FACTOR = 32,
  parameter int unsigned CHANNELS          = 2,
  parameter int unsigned MULT_PER_CYCLE    = 1,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned FRAC_BITS         = 0,
  parameter int unsigned SATURATE          = 0,
  parameter logic signed [DATA_WIDTH-1:0] TAPS [TAP_COUNT] = '{default: DATA_WIDTH'(1)}
) (
  input  logic           clock,
  input  logic           reset,
  fir_decim_mc_if.slave  bus
);

  localparam int unsigned M      = TAP_COUNT / MULT_PER_CYCLE;
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, TAP_COUNT);
  localparam int unsigned CH_W   = $clog2(CHANNELS) + 1;
  localparam int unsigned CH_IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TAP_IW = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam int unsigned MC_W   = $clog2(M + 1);
  localparam int unsigned DC_W   = $clog2(DECIMATION_FACTOR + 1);

  state_e                        state_q;
  logic signed [DATA_WIDTH-1:0]  hist_q [CHANNELS][TAP_COUNT];
  logic [DC_W-1:0]               dec_cnt_q;
  logic [MC_W-1:0]               mac_cnt_q;
  logic [CH_W-1:0]               ch_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic [DATA_WIDTH-1:0]         out_data_q;
  logic [CH_W-1:0]               out_chan_q;

  logic [CH_IW-1:0]              ch_idx;
  logic [TAP_IW-1:0]             tap_idx;
  logic signed [DATA_WIDTH-1:0]  lane_samp [MULT_PER_CYCLE];
  logic signed [DATA_WIDTH-1:0]  lane_coef [MULT_PER_CYCLE];
  logic signed [ACC_W-1:0]       lane_sum;
  logic signed [ACC_W-1:0]       acc_d;
  logic [DATA_WIDTH-1:0]         out_data_d;

  assign ch_idx = ch_q[CH_IW-1:0];

  always_comb begin
    lane_samp = '{default: '0};
    lane_coef = '{default: '0};
    tap_idx   = '0;
    for (int unsigned i = 0; i < MULT_PER_CYCLE; i++) begin
      tap_idx      = TAP_IW'(mac_cnt_q * MULT_PER_CYCLE + i);
      lane_samp[i] = hist_q[ch_idx][tap_idx];
      lane_coef[i] = TAPS[tap_idx];
    end
  end

  fir_mac_lane #(
    .N  (MULT_PER_CYCLE),
    .DW (DATA_WIDTH),
    .SW (ACC_W)
  ) u_lane (
    .samp_i (lane_samp),
    .coef_i (lane_coef),
    .sum_o  (lane_sum)
  );

  // The last MAC cycle rescales the sum including its own partial product.
  assign acc_d      = acc_q + lane_sum;
  assign out_data_d = DATA_WIDTH'(sat_trunc(SAT_ACC_W'(acc_d), FRAC_BITS, SATURATE != 0, DATA_WIDTH));

  assign bus.in_rd_en  = (state_q == S_LOAD) && !bus.in_empty && !reset;
  assign bus.out_wr_en = (state_q == S_OUT) && !bus.out_full && !reset;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_LOAD;
      dec_cnt_q  <= '0;
      mac_cnt_q  <= '0;
      ch_q       <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_chan_q <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned k = 0; k < TAP_COUNT; k++) begin
          hist_q[c][k] <= '0;
        end
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (!bus.in_empty) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              hist_q[c][0] <= bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
              for (int unsigned k = 1; k < TAP_COUNT; k++) begin
                hist_q[c][k] <= hist_q[c][k-1];
              end
            end
            if (dec_cnt_q == DC_W'(DECIMATION_FACTOR - 1)) begin
              dec_cnt_q <= '0;
              ch_q      <= '0;
              acc_q     <= '0;
              mac_cnt_q <= '0;
              state_q   <= S_MAC;
            end else begin
              dec_cnt_q <= dec_cnt_q + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (mac_cnt_q == MC_W'(M - 1)) begin
            mac_cnt_q  <= '0;
            out_data_q <= out_data_d;
            out_chan_q <= ch_q;
            state_q    <= S_OUT;
          end else begin
            mac_cnt_q <= mac_cnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (!bus.out_full) begin
            if (ch_q < CH_W'(CHANNELS - 1)) begin
              ch_q    <= ch_q + 1'b1;
              acc_q   <= '0;
              state_q <= S_MAC;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule
